// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO register unit: widths, divider FSM states, ALU opcodes.
package hilo_unit_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_RUN  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    typedef enum logic [4:0] {
        ALUOP_NOP  = 5'd0,
        ALUOP_ADD  = 5'd1,
        ALUOP_SUB  = 5'd2,
        ALUOP_AND  = 5'd3,
        ALUOP_OR   = 5'd4,
        ALUOP_XOR  = 5'd5,
        ALUOP_NOR  = 5'd6,
        ALUOP_SLT  = 5'd7,
        ALUOP_SLTU = 5'd8,
        ALUOP_SLL  = 5'd9,
        ALUOP_SRL  = 5'd10,
        ALUOP_SRA  = 5'd11,
        ALUOP_MFHI = 5'd12,
        ALUOP_MFLO = 5'd13,
        ALUOP_MTHI = 5'd14,
        ALUOP_MTLO = 5'd15,
        ALUOP_DIV  = 5'd16,
        ALUOP_DIVU = 5'd17
    } aluop_e;

endpackage

// File: rtl/hilo_unit_if.sv
// HILO write stream, read-back and divider handshake between execute (master) and hilo_unit (slave).
interface hilo_unit_if #(parameter int DATA_W = hilo_unit_pkg::DATA_W);

    logic              wb_hilo_we;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic [DATA_W-1:0] rd_hi;
    logic [DATA_W-1:0] rd_lo;
    logic              div_start;
    logic              div_signed;
    logic [DATA_W-1:0] div_op1;
    logic [DATA_W-1:0] div_op2;
    logic              div_cancel;
    logic              div_busy;
    logic              div_done;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] div_r;
    logic              stall_req;

    modport master (
        output wb_hilo_we, wb_hi, wb_lo,
        output div_start, div_signed, div_op1, div_op2, div_cancel,
        input  rd_hi, rd_lo,
        input  div_busy, div_done, div_q, div_r, stall_req
    );

    modport slave (
        input  wb_hilo_we, wb_hi, wb_lo,
        input  div_start, div_signed, div_op1, div_op2, div_cancel,
        output rd_hi, rd_lo,
        output div_busy, div_done, div_q, div_r, stall_req
    );

endinterface

// File: rtl/hilo_unit_div_core.sv
// Iterative restoring DIV/DIVU engine with start/busy/done handshake and stall request.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// DIV_IDLE | waiting for an accepted start
// DIV_ZERO | divisor was zero: load q=all-ones, r=dividend
// DIV_RUN  | one shift/subtract step per cycle, DATA_W steps total
// DIV_DONE | results valid, div_done pulses for this one cycle
module div_core
    import hilo_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] r,
    output logic              stall_req
);

    div_state_e        state_q, state_d;
    logic [DATA_W-1:0] rem_q, quot_q, dvsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sgn_op_q, sgn1_q, sgn2_q;

    logic              accept;
    logic              last_step;
    logic [DATA_W:0]   rem_sh, diff;
    logic [DATA_W-1:0] rem_nx, quot_nx;
    logic [DATA_W-1:0] mag1, mag2;

    assign accept    = (state_q == DIV_IDLE) && start && !cancel;
    assign last_step = (cnt_q == CNT_W'(DATA_W - 1));
    assign mag1      = (signed_op && op1[DATA_W-1]) ? -op1 : op1;
    assign mag2      = (signed_op && op2[DATA_W-1]) ? -op2 : op2;

    // The shifted remainder needs one extra bit before the trial subtract.
    always_comb begin
        rem_sh = {rem_q, quot_q[DATA_W-1]};
        diff   = rem_sh - {1'b0, dvsr_q};
        if (!diff[DATA_W]) begin
            rem_nx  = diff[DATA_W-1:0];
            quot_nx = {quot_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_nx  = rem_sh[DATA_W-1:0];
            quot_nx = {quot_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= DIV_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        if (state_q == DIV_ZERO || state_q == DIV_RUN || accept) stall_req = 1'b1;
        if (cancel) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: if (start) state_d = (op2 == '0) ? DIV_ZERO : DIV_RUN;
                DIV_ZERO: state_d = DIV_DONE;
                DIV_RUN:  if (last_step) state_d = DIV_DONE;
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    assign busy = (state_q != DIV_IDLE);
    assign done = (state_q == DIV_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            sgn_op_q <= 1'b0;
            sgn1_q   <= 1'b0;
            sgn2_q   <= 1'b0;
            q        <= '0;
            r        <= '0;
        end else if (accept) begin
            // A zero divisor keeps the raw dividend in quot_q for the remainder.
            quot_q   <= (op2 == '0) ? op1 : mag1;
            dvsr_q   <= mag2;
            rem_q    <= '0;
            cnt_q    <= '0;
            sgn_op_q <= signed_op;
            sgn1_q   <= op1[DATA_W-1];
            sgn2_q   <= op2[DATA_W-1];
        end else if (!cancel) begin
            if (state_q == DIV_ZERO) begin
                q <= '1;
                r <= quot_q;
            end else if (state_q == DIV_RUN) begin
                rem_q  <= rem_nx;
                quot_q <= quot_nx;
                cnt_q  <= cnt_q + CNT_W'(1);
                if (last_step) begin
                    q <= (sgn_op_q && (sgn1_q ^ sgn2_q)) ? -quot_nx : quot_nx;
                    r <= (sgn_op_q && sgn1_q) ? -rem_nx : rem_nx;
                end
            end
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO register pair plus the iterative divider.
// Optional HILO_WB_BYPASS_EN: rd_hi/rd_lo forward wb_hi/wb_lo in the write cycle.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    hilo_unit_if.slave  hif
);

    logic [DATA_W-1:0] hi_q, lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hif.wb_hilo_we) begin
            hi_q <= hif.wb_hi;
            lo_q <= hif.wb_lo;
        end
    end

`ifdef HILO_WB_BYPASS_EN
    assign hif.rd_hi = hif.wb_hilo_we ? hif.wb_hi : hi_q;
    assign hif.rd_lo = hif.wb_hilo_we ? hif.wb_lo : lo_q;
`else
    assign hif.rd_hi = hi_q;
    assign hif.rd_lo = lo_q;
`endif

    div_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (hif.div_start),
        .signed_op (hif.div_signed),
        .op1       (hif.div_op1),
        .op2       (hif.div_op2),
        .cancel    (hif.div_cancel),
        .busy      (hif.div_busy),
        .done      (hif.div_done),
        .q         (hif.div_q),
        .r         (hif.div_r),
        .stall_req (hif.stall_req)
    );

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: HI/LO write/read, divide vector table, cancel and reset corners.
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hilo_unit_if #(.DATA_W(32)) hif ();

    hilo_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        sgn;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        int          exp_lat;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts a divide and runs it to div_done; optionally pokes a second start at cycle intr.
    task automatic run_div(input vec_t v, input int intr);
        int  lat;
        int  stl;
        bit  seen;
        @(negedge clk);
        hif.div_start  = 1'b1;
        hif.div_signed = v.sgn;
        hif.div_op1    = v.op1;
        hif.div_op2    = v.op2;
        #1;
        chk("stall_on_accept", 32'(hif.stall_req), 32'd1);
        lat  = 0;
        stl  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (hif.div_done) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
            if (hif.stall_req) stl++;
            if (i == 1) hif.div_start = 1'b0;
            if (intr != 0 && i == intr) begin
                hif.div_start  = 1'b1;
                hif.div_signed = 1'b0;
                hif.div_op1    = 32'd50;
                hif.div_op2    = 32'd5;
            end
            if (intr != 0 && i == intr + 1) hif.div_start = 1'b0;
        end
        hif.div_start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("stall_cycles", 32'(stl), 32'(v.exp_lat - 1));
        chk("stall_in_done", 32'(hif.stall_req), 32'd0);
        chk("quotient", hif.div_q, v.exp_q);
        chk("remainder", hif.div_r, v.exp_r);
        @(negedge clk);
        chk("busy_after_done", 32'(hif.div_busy), 32'd0);
        chk("done_one_cycle", 32'(hif.div_done), 32'd0);
        chk("q_hold", hif.div_q, v.exp_q);
    endtask

    vec_t vecs[8];

    initial begin
        int dn;
        vec_t v;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33};
        vecs[1] = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   33};
        vecs[2] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          33};
        vecs[3] = '{32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          2};
        vecs[4] = '{32'hFFFFFF9C,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFF9C,   2};
        vecs[5] = '{32'hFFFFFFFF,   32'h10,         1'b0, 32'h0FFFFFFF,   32'hF,          33};
        vecs[6] = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          33};
        vecs[7] = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   33};

        hif.wb_hilo_we = 1'b0;
        hif.wb_hi      = '0;
        hif.wb_lo      = '0;
        hif.div_start  = 1'b0;
        hif.div_signed = 1'b0;
        hif.div_op1    = '0;
        hif.div_op2    = '0;
        hif.div_cancel = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_rd_hi", hif.rd_hi, 32'd0);
        chk("rst_rd_lo", hif.rd_lo, 32'd0);
        chk("rst_q", hif.div_q, 32'd0);
        chk("rst_r", hif.div_r, 32'd0);
        chk("rst_ctl", {29'd0, hif.div_busy, hif.div_done, hif.stall_req}, 32'd0);

        // HI/LO write and read-back
        hif.wb_hilo_we = 1'b1;
        hif.wb_hi      = 32'h12345678;
        hif.wb_lo      = 32'h9ABCDEF0;
        #1;
`ifdef HILO_WB_BYPASS_EN
        chk("bypass_hi", hif.rd_hi, 32'h12345678);
        chk("bypass_lo", hif.rd_lo, 32'h9ABCDEF0);
`else
        chk("nobypass_hi", hif.rd_hi, 32'd0);
        chk("nobypass_lo", hif.rd_lo, 32'd0);
`endif
        @(negedge clk);
        hif.wb_hilo_we = 1'b0;
        hif.wb_hi      = 32'hDEADBEEF;
        hif.wb_lo      = 32'hCAFEF00D;
        #1;
        chk("rd_hi", hif.rd_hi, 32'h12345678);
        chk("rd_lo", hif.rd_lo, 32'h9ABCDEF0);
        @(negedge clk);
        chk("hold_hi", hif.rd_hi, 32'h12345678);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("clr_hi", hif.rd_hi, 32'd0);
        chk("clr_lo", hif.rd_lo, 32'd0);

        // Divide vector table
        for (int k = 0; k < 8; k++) run_div(vecs[k], 0);

        // Second start while busy is ignored
        run_div(vecs[0], 5);

        // Cancel at cycle 10 of a run: back to IDLE, no done
        @(negedge clk);
        hif.div_start  = 1'b1;
        hif.div_signed = 1'b0;
        hif.div_op1    = 32'd1000;
        hif.div_op2    = 32'd3;
        @(negedge clk);
        hif.div_start = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_cancel", 32'(hif.div_busy), 32'd1);
        hif.div_cancel = 1'b1;
        @(negedge clk);
        hif.div_cancel = 1'b0;
        chk("cancel_busy", 32'(hif.div_busy), 32'd0);
        chk("cancel_stall", 32'(hif.stall_req), 32'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hif.div_done) dn++;
        end
        chk("cancel_no_done", 32'(dn), 32'd0);

        // Cancel together with start in IDLE: cancel wins
        hif.div_start  = 1'b1;
        hif.div_cancel = 1'b1;
        @(negedge clk);
        hif.div_start  = 1'b0;
        hif.div_cancel = 1'b0;
        chk("cancel_wins", 32'(hif.div_busy), 32'd0);

        // Reset at cycle 15 of RUN, with a HI/LO value and an old result present
        hif.wb_hilo_we = 1'b1;
        hif.wb_hi      = 32'h11111111;
        hif.wb_lo      = 32'h22222222;
        hif.div_start  = 1'b1;
        hif.div_signed = 1'b0;
        hif.div_op1    = 32'd1000;
        hif.div_op2    = 32'd3;
        @(negedge clk);
        hif.wb_hilo_we = 1'b0;
        hif.div_start  = 1'b0;
        chk("wb_during_div", hif.rd_hi, 32'h11111111);
        repeat (14) @(negedge clk);
        chk("busy_before_rst", 32'(hif.div_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_q", hif.div_q, 32'd0);
        chk("mid_rst_r", hif.div_r, 32'd0);
        chk("mid_rst_hi", hif.rd_hi, 32'd0);
        chk("mid_rst_lo", hif.rd_lo, 32'd0);
        chk("mid_rst_ctl", {29'd0, hif.div_busy, hif.div_done, hif.stall_req}, 32'd0);

        v = '{32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33};
        run_div(v, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
